// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronises 7 request lines, latches rising edges, masks, grants highest index.
// Request valid 1 edge after eligibility; holds until inter rises, blocks until eirq plus one GAP cycle.
module irq_arbiter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] src_req,
  input  logic       mask_we,
  input  logic [6:0] mask_wdata,
  input  logic       pend_clr,
  input  logic [2:0] pend_clr_sel,
  input  logic       inter,
  input  logic       eirq,
  output logic       irq1,
  output logic       irq2,
  output logic       irq3,
  output logic [2:0] active,
  output logic [6:0] pending,
  output logic [6:0] mask
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE,
    GAP
  } state_t;

  state_t                       state_q, state_d;
  logic [SYNC_STAGES-1:0][6:0]  sync_q, sync_d;
  logic [6:0]                   edge_q, edge_d;
  logic [6:0]                   pend_q, pend_d;
  logic [6:0]                   mask_q, mask_d;
  logic [2:0]                   irq_q, irq_d;
  logic [2:0]                   active_q, active_d;
  logic                         inter_q, inter_d;
  logic [6:0]                   rise;
  logic [6:0]                   elig;
  logic [2:0]                   win_code;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src_req};
    edge_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  // Ascending scan so the highest eligible index is the one left standing.
  always_comb begin
    elig     = pend_q & mask_q;
    win_code = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (elig[i]) win_code = 3'(i + 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    active_d = active_q;
    pend_d   = pend_q;
    mask_d   = mask_we ? mask_wdata : mask_q;
    inter_d  = inter;

    if (pend_clr && (pend_clr_sel != 3'd7)) pend_d[pend_clr_sel] = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_code != 3'd0) begin
          irq_d   = win_code;
          state_d = REQ;
        end
      end
      REQ: begin
        if (inter && !inter_q) begin
          pend_d[irq_q - 3'd1] = 1'b0;
          active_d             = irq_q;
          irq_d                = 3'd0;
          state_d              = SERVICE;
        end
      end
      SERVICE: begin
        if (eirq) begin
          active_d = 3'd0;
          state_d  = GAP;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge outranks both software and grant clears.
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      irq_q    <= '0;
      active_q <= '0;
      inter_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      edge_q   <= edge_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
      active_q <= active_d;
      inter_q  <= inter_d;
    end
  end

  assign irq1    = irq_q[0];
  assign irq2    = irq_q[1];
  assign irq3    = irq_q[2];
  assign active  = active_q;
  assign pending = pend_q;
  assign mask    = mask_q;

endmodule
